// File: rtl/ifm_write_ctrl.sv
// Round-robin loader that spreads a pixel-beat stream across SIZE feature-map banks.
// Optional build macro IFM_WR_REG_OUT_EN adds one output register stage on the bank write ports.

module ifm_bank_slice #(
  parameter int AW = 5,
  parameter int DW = 128
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          wr,
  input  logic          row_upd,
  input  logic [AW-1:0] row,
  input  logic [DW-1:0] data,
  output logic          wr_en,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] pix
);
  logic          en_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] pix_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      pix_q  <= '0;
    end else begin
      en_q <= wr;
      if (row_upd) addr_q <= row;
      if (wr)      pix_q  <= data;
    end
  end

`ifdef IFM_WR_REG_OUT_EN
  logic          en_q2;
  logic [AW-1:0] addr_q2;
  logic [DW-1:0] pix_q2;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      en_q2   <= 1'b0;
      addr_q2 <= '0;
      pix_q2  <= '0;
    end else begin
      en_q2   <= en_q;
      addr_q2 <= addr_q;
      pix_q2  <= pix_q;
    end
  end

  assign wr_en = en_q2;
  assign addr  = addr_q2;
  assign pix   = pix_q2;
`else
  assign wr_en = en_q;
  assign addr  = addr_q;
  assign pix   = pix_q;
`endif
endmodule

module ifm_write_ctrl #(
  parameter int SIZE = 8
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4:0]          cfg_depth,
  input  logic [3:0]          cfg_valid_num,
  input  logic                buf_empty,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  input  logic                in_last,
  output logic [SIZE-1:0]     ifm_wr_en,
  output logic [5*SIZE-1:0]   ifm_wr_addr,
  output logic [128*SIZE-1:0] pixels_in,
  output logic [3:0]          valid_num,
  output logic                i2c_ready,
  input  logic                i2c_done,
  output logic                load_err
);
  localparam int BW = (SIZE > 1) ? $clog2(SIZE) : 1;
`ifdef IFM_WR_REG_OUT_EN
  localparam int STAGES = 1;
`else
  localparam int STAGES = 0;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t          state, state_nxt;
  logic [BW-1:0]   bank_cnt;
  logic [4:0]      row_cnt;
  logic [4:0]      depth_q;
  logic            accept, start_ok, final_beat, bank_wrap, rdy_now;
  logic [SIZE-1:0] bank_wr;
  logic [STAGES:0] vld_pipe;
  logic [SIZE-1:0][4:0]   addr_arr;
  logic [SIZE-1:0][127:0] pix_arr;

  assign bank_wrap  = (bank_cnt == BW'(SIZE-1));
  assign final_beat = bank_wrap && (row_cnt == depth_q);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && buf_empty)                  state_nxt = LOAD;
      LOAD:    if (accept && (in_last || final_beat))   state_nxt = READY;
      READY:   if (i2c_done)                            state_nxt = IDLE;
      default:                                          state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == LOAD);
    accept   = in_ready && in_valid;
    start_ok = (state == IDLE) && start && buf_empty;
    rdy_now  = (state == READY) && !i2c_done;
    for (int i = 0; i < SIZE; i++)
      bank_wr[i] = accept && (bank_cnt == BW'(i));
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      bank_cnt  <= '0;
      row_cnt   <= '0;
      depth_q   <= '0;
      valid_num <= '0;
      load_err  <= 1'b0;
    end else if (start_ok) begin
      bank_cnt  <= '0;
      row_cnt   <= '0;
      depth_q   <= cfg_depth;
      valid_num <= cfg_valid_num;
      load_err  <= 1'b0;
    end else if (accept) begin
      bank_cnt <= bank_wrap ? '0 : bank_cnt + 1'b1;
      if (bank_wrap) row_cnt <= row_cnt + 1'b1;
      // Length mismatch in either direction: last flag and final slot must coincide.
      if (in_last != final_beat) load_err <= 1'b1;
    end
  end

  // Tile-resident flag trails the state by the bank write latency; drops as soon as done arrives.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else begin
      vld_pipe[0] <= rdy_now;
      for (int i = 1; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1] && rdy_now;
    end
  end
  assign i2c_ready = vld_pipe[STAGES];

  for (genvar g = 0; g < SIZE; g++) begin : g_bank
    ifm_bank_slice #(.AW(5), .DW(128)) u_slice (
      .clock   (clock),
      .rst_n   (rst_n),
      .wr      (bank_wr[g]),
      .row_upd (accept),
      .row     (row_cnt),
      .data    (in_data),
      .wr_en   (ifm_wr_en[g]),
      .addr    (addr_arr[g]),
      .pix     (pix_arr[g])
    );
  end

  assign ifm_wr_addr = addr_arr;
  assign pixels_in   = pix_arr;
endmodule

// File: tb/tb_ifm_write_ctrl.sv
// Directed bench for ifm_write_ctrl (default build, SIZE=8).
module tb_ifm_write_ctrl;
  localparam int SIZE = 8;

  logic                clock, rst_n, start, buf_empty, in_valid, in_last, i2c_done;
  logic [4:0]          cfg_depth;
  logic [3:0]          cfg_valid_num;
  logic [127:0]        in_data;
  logic                in_ready, i2c_ready, load_err;
  logic [SIZE-1:0]     ifm_wr_en;
  logic [5*SIZE-1:0]   ifm_wr_addr;
  logic [128*SIZE-1:0] pixels_in;
  logic [3:0]          valid_num;

  int errs = 0;
  int checks = 0;

  ifm_write_ctrl #(.SIZE(SIZE)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .cfg_depth(cfg_depth),
    .cfg_valid_num(cfg_valid_num), .buf_empty(buf_empty), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .ifm_wr_en(ifm_wr_en), .ifm_wr_addr(ifm_wr_addr), .pixels_in(pixels_in),
    .valid_num(valid_num), .i2c_ready(i2c_ready), .i2c_done(i2c_done),
    .load_err(load_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [127:0] pix(input int k);
    logic [31:0] w;
    w = 32'hC0DE0000 + 32'(k);
    return {4{w}};
  endfunction

  task automatic do_start(input logic [4:0] d, input logic [3:0] vn);
    cfg_depth = d; cfg_valid_num = vn; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic done_pulse();
    i2c_done = 1'b1;
    step();
    i2c_done = 1'b0;
  endtask

  task automatic beat(input int k, input logic last);
    in_valid = 1'b1; in_data = pix(k); in_last = last;
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Write visible one cycle after acceptance: beat k lands in bank k%SIZE, row k/SIZE.
  task automatic chk_write(input string tag, input int k);
    int b;
    logic [SIZE-1:0] en;
    b  = k % SIZE;
    en = SIZE'(1) << b;
    chk({tag, "_en"},   ifm_wr_en, en);
    chk({tag, "_addr"}, ifm_wr_addr[b*5 +: 5], 5'(k / SIZE));
    chk({tag, "_data"}, pixels_in[b*128 +: 128], pix(k));
  endtask

  initial begin
    int gaps [8] = '{2, 0, 1, 3, 0, 1, 0, 0};
    int acc;
    rst_n = 1'b0; start = 1'b0; buf_empty = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    i2c_done = 1'b0; cfg_depth = '0; cfg_valid_num = '0; in_data = '0;
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", ifm_wr_en, 0);
    chk("rst_addr", ifm_wr_addr, 0);
    chk("rst_pix", |pixels_in, 0);
    chk("rst_i2c_ready", i2c_ready, 0);
    chk("rst_load_err", load_err, 0);
    @(posedge clock); #1;
    rst_n = 1'b1;
    step();

    // Nominal 2-row tile
    do_start(5'd1, 4'd7);
    chk("nom_in_ready", in_ready, 1);
    chk("nom_valid_num", valid_num, 7);
    for (int k = 0; k < 16; k++) begin
      beat(k, k == 15);
      chk_write("nom", k);
    end
    chk("nom_ready_drop", in_ready, 0);
    chk("nom_i2c_n1", i2c_ready, 0);
    chk("nom_err", load_err, 0);
    step();
    chk("nom_i2c_n2", i2c_ready, 1);
    chk("nom_en_idle", ifm_wr_en, 0);
    chk("nom_done_hold", i2c_ready, 1);
    done_pulse();
    chk("nom_i2c_drop", i2c_ready, 0);
    chk("nom_idle_in_ready", in_ready, 0);

    // in_valid gaps
    do_start(5'd0, 4'd3);
    for (int k = 0; k < 8; k++) begin
      beat(k, k == 7);
      chk_write("gap", k);
      if (k < 7)
        for (int g = 0; g < gaps[k]; g++) begin
          step();
          chk("gap_no_wr", ifm_wr_en, 0);
        end
    end
    chk("gap_err", load_err, 0);
    step();
    chk("gap_i2c", i2c_ready, 1);
    done_pulse();

    // Early in_last on beat 5
    do_start(5'd0, 4'd1);
    for (int k = 0; k < 5; k++) beat(k, k == 4);
    chk("early_err", load_err, 1);
    chk("early_in_ready", in_ready, 0);
    in_valid = 1'b1; in_data = pix(99);
    step();
    in_valid = 1'b0;
    chk("early_no_wr", ifm_wr_en, 0);
    chk("early_i2c", i2c_ready, 1);
    done_pulse();

    // Missing in_last: 10 offered, 8 taken
    do_start(5'd0, 4'd2);
    chk("late_err_clr", load_err, 0);
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      if (in_ready) acc++;
      in_valid = 1'b1; in_data = pix(k); in_last = 1'b0;
      step();
    end
    in_valid = 1'b0;
    chk("late_acc", acc, 8);
    chk("late_err", load_err, 1);
    chk("late_last_data", pixels_in[7*128 +: 128], pix(7));
    chk("late_i2c", i2c_ready, 1);
    chk("late_no_wr", ifm_wr_en, 0);
    done_pulse();

    // start dropped while buffer not empty
    buf_empty = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("bufne_in_ready", in_ready, 0);
    chk("bufne_err_sticky", load_err, 1);
    step();
    chk("bufne_in_ready2", in_ready, 0);
    buf_empty = 1'b1;
    do_start(5'd1, 4'd5);
    chk("bufe_in_ready", in_ready, 1);
    chk("bufe_err_clr", load_err, 0);
    chk("bufe_valid_num", valid_num, 5);

    // Reset mid-load after 3 beats
    for (int k = 0; k < 3; k++) beat(k, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_wr_en", ifm_wr_en, 0);
    chk("mrst_addr", ifm_wr_addr, 0);
    chk("mrst_pix", |pixels_in, 0);
    chk("mrst_valid_num", valid_num, 0);
    chk("mrst_i2c", i2c_ready, 0);
    chk("mrst_err", load_err, 0);
    step();
    rst_n = 1'b1;
    step();
    do_start(5'd1, 4'd6);
    beat(40, 1'b0);
    chk("post_rst_en", ifm_wr_en, 8'h01);
    chk("post_rst_addr", ifm_wr_addr[4:0], 0);
    chk("post_rst_data", pixels_in[127:0], pix(40));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
